// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the master-clock control blocks.
//   mc_state_t : 3-bit state encoding of the clock-enable sequencer
//                (INIT=0, IDLE=1, WAKE=2, RUN=3, DRAIN=4; 5-7 unused).
//   dly_width  : width needed by a down-counter that is loaded with
//                (delay - 1) for the largest of three delays.
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WAKE  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } mc_state_t;

    // The counter never holds more than (delay - 1), so clog2(delay) bits
    // suffice; a single-cycle delay still needs one bit to exist.
    function automatic int dly_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mc_seq_if.sv
// ---------------------------------------------------------------------------
// mc_seq_if
// Client-side bundle of the master-clock sequencer.
//   req     : level run request per client        (master -> slave)
//   halt    : forced stop                          (master -> slave)
//   clk_en  : enable to the master clock           (slave -> master)
//   ack     : per-client grant                     (slave -> master)
//   state   : sequencer state encoding             (slave -> master)
//   run_cnt : saturating count of enabled cycles   (slave -> master)
//   busy    : sequencer not in IDLE                (slave -> master)
// ---------------------------------------------------------------------------
interface mc_seq_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0] req;
    logic             halt;
    logic             clk_en;
    logic [N_REQ-1:0] ack;
    logic [2:0]       state;
    logic [CNT_W-1:0] run_cnt;
    logic             busy;

    modport master (
        output req, halt,
        input  clk_en, ack, state, run_cnt, busy
    );

    modport slave (
        input  req, halt,
        output clk_en, ack, state, run_cnt, busy
    );
endinterface

// File: rtl/mc_dly_cnt.sv
// ---------------------------------------------------------------------------
// mc_dly_cnt
// Loadable down-counter shared by the sequencer's timed states.
//   clk      : clock
//   rst      : synchronous active-high reset, loads RST_VAL
//   load     : load load_val (takes effect on this edge)
//   load_val : value to load, normally (delay - 1)
//   clr      : force the count to zero (wins over load)
//   done     : count is zero; the running delay has expired
// The count stops at zero, so done stays high until the next load.
// ---------------------------------------------------------------------------
module mc_dly_cnt #(
    parameter int           W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    output logic         done
);
    logic [W-1:0] cnt;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking assignments here would create order races.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/mc_seq.sv
// ---------------------------------------------------------------------------
// mc_seq
// Clock-enable sequencer for the master clock. Collects run requests from
// N_REQ clients and drives clk_en with a post-reset hold-off, a wake delay
// and an off-drain delay; grants ack to requesting clients while running.
//   clk : always-on clock, all logic on its rising edge
//   rst : synchronous active-high reset
//   bus : mc_seq_if slave port (req/halt in; clk_en/ack/state/run_cnt/busy
//         out). The interface instance must use the same N_REQ and CNT_W.
// ---------------------------------------------------------------------------
module mc_seq
    import mc_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int STARTUP_CYC = 8,
    parameter int ON_DELAY    = 2,
    parameter int OFF_DELAY   = 4,
    parameter int CNT_W       = 16
) (
    input  logic     clk,
    input  logic     rst,
    mc_seq_if.slave  bus
);
    localparam int DLY_W = dly_width(STARTUP_CYC, ON_DELAY, OFF_DELAY);

    // Each timed state is entered with (delay - 1) loaded, so the exit
    // decision falls exactly delay edges after the entering edge.
    localparam logic [DLY_W-1:0] INIT_LD  = DLY_W'(STARTUP_CYC - 1);
    localparam logic [DLY_W-1:0] WAKE_LD  = DLY_W'(ON_DELAY - 1);
    localparam logic [DLY_W-1:0] DRAIN_LD = DLY_W'(OFF_DELAY - 1);

    mc_state_t        state;
    logic             clk_en_q;
    logic [N_REQ-1:0] ack_q;
    logic [CNT_W-1:0] run_cnt_q;

    logic             any_req;
    logic             abort;
    logic             dly_load;
    logic             dly_clr;
    logic [DLY_W-1:0] dly_val;
    logic             dly_done;

    assign any_req = |bus.req;

    // halt only acts once the clock has been asked for; INIT and IDLE
    // simply ignore it (IDLE by refusing to wake).
    assign abort = bus.halt && (state inside {ST_WAKE, ST_RUN, ST_DRAIN});

    // Delay-counter control: load on entry to WAKE/DRAIN (INIT is entered
    // only through reset, which loads the counter itself), clear on abort
    // and when a request pulls DRAIN back to RUN.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        dly_load = 1'b0;
        dly_clr  = 1'b0;
        dly_val  = WAKE_LD;
        if (abort) begin
            dly_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req && !bus.halt) begin
                        dly_load = 1'b1;
                        dly_val  = WAKE_LD;
                    end
                end
                ST_RUN: begin
                    if (!any_req) begin
                        dly_load = 1'b1;
                        dly_val  = DRAIN_LD;
                    end
                end
                ST_DRAIN: begin
                    if (any_req) dly_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    mc_dly_cnt #(
        .W       (DLY_W),
        .RST_VAL (INIT_LD)
    ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load),
        .load_val (dly_val),
        .clr      (dly_clr),
        .done     (dly_done)
    );

    // FSM with registered clk_en/ack. Priority: rst, halt, delay expiry,
    // request change -- except in DRAIN, where a returning request beats
    // the expiry so clk_en never drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            clk_en_q <= 1'b0;
            ack_q    <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            clk_en_q <= 1'b0;
            ack_q    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    clk_en_q <= 1'b0;
                    ack_q    <= '0;
                    if (dly_done) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    clk_en_q <= 1'b0;
                    ack_q    <= '0;
                    if (any_req && !bus.halt) state <= ST_WAKE;
                end
                ST_WAKE: begin
                    // Completes to RUN even if every request has dropped;
                    // RUN then drains on the next edge.
                    if (dly_done) begin
                        state    <= ST_RUN;
                        clk_en_q <= 1'b1;
                        ack_q    <= bus.req;
                    end
                end
                ST_RUN: begin
                    if (!any_req) begin
                        state <= ST_DRAIN;
                        ack_q <= '0;
                    end else begin
                        ack_q <= bus.req;
                    end
                end
                ST_DRAIN: begin
                    if (any_req) begin
                        state <= ST_RUN;
                        ack_q <= bus.req;
                    end else if (dly_done) begin
                        state    <= ST_IDLE;
                        clk_en_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clk_en_q <= 1'b0;
                    ack_q    <= '0;
                end
            endcase
        end
    end

    // Counts edges on which the enable was high; holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
        end else if (clk_en_q && (run_cnt_q != '1)) begin
            run_cnt_q <= run_cnt_q + 1'b1;
        end
    end

    assign bus.clk_en  = clk_en_q;
    assign bus.ack     = ack_q;
    assign bus.state   = state;
    assign bus.run_cnt = run_cnt_q;
    assign bus.busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_mc_seq.sv
// ---------------------------------------------------------------------------
// tb_mc_seq
// Self-checking bench for mc_seq. A default-parameter instance covers
// hold-off, run/drain, re-wake, halt and reset; a CNT_W=4 instance covers
// run_cnt saturation. Expected outputs are queued when the stimulus for an
// edge is driven and popped for comparison just after that edge.
// ---------------------------------------------------------------------------
module tb_mc_seq;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_WAKE  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_seq_if #(.N_REQ(4), .CNT_W(16)) bus   ();
    mc_seq_if #(.N_REQ(4), .CNT_W(4))  bus_s ();

    mc_seq #(
        .N_REQ(4), .STARTUP_CYC(8), .ON_DELAY(2), .OFF_DELAY(4), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mc_seq #(
        .N_REQ(4), .STARTUP_CYC(8), .ON_DELAY(2), .OFF_DELAY(4), .CNT_W(4)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        en;
        logic [3:0]  ack;
        logic [15:0] cnt;
        bit          use_cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void push_exp(input string n, input logic [2:0] st,
                                     input logic en, input logic [3:0] a,
                                     input logic [15:0] c, input bit uc);
        exp_t e;
        e.name = n; e.st = st; e.en = en; e.ack = a; e.cnt = c; e.use_cnt = uc;
        sb.push_back(e);
    endfunction

    // Drive the inputs for the next edge, then step to just after it.
    task automatic tick(input logic [3:0] r, input logic h, input logic rs);
        bus.req  = r;
        bus.halt = h;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int j = 0; j < 2; j++) begin
            push_exp("reset", S_INIT, 1'b0, 4'b0000, 16'd0, 1'b1);
            tick(4'b0001, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (bus.state !== e.st || bus.clk_en !== e.en || bus.ack !== e.ack ||
                bus.busy !== (e.st != S_IDLE) || (e.use_cnt && bus.run_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL %s[%0d]: got st=%0d en=%b ack=%b busy=%b cnt=%0d want st=%0d en=%b ack=%b cnt=%0d",
                         e.name, j, bus.state, bus.clk_en, bus.ack, bus.busy, bus.run_cnt,
                         e.st, e.en, e.ack, e.cnt);
            end
        end
    endtask

    // Reset released; req held from the first cycle, halt pulsed in INIT.
    task automatic test_holdoff();
        exp_t       e;
        logic [2:0] st;
        for (int j = 1; j <= 11; j++) begin
            if (j < 8)       st = S_INIT;
            else if (j == 8) st = S_IDLE;
            else if (j < 11) st = S_WAKE;
            else             st = S_RUN;
            push_exp("holdoff", st, j == 11, (j == 11) ? 4'b0001 : 4'b0000, 16'd0, 1'b1);
            tick(4'b0001, j == 3, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.state !== e.st || bus.clk_en !== e.en || bus.ack !== e.ack ||
                bus.busy !== (e.st != S_IDLE) || (e.use_cnt && bus.run_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL %s[%0d]: got st=%0d en=%b ack=%b busy=%b cnt=%0d want st=%0d en=%b ack=%b cnt=%0d",
                         e.name, j, bus.state, bus.clk_en, bus.ack, bus.busy, bus.run_cnt,
                         e.st, e.en, e.ack, e.cnt);
            end
        end
    endtask

    // req[2] for 12 sampled edges from IDLE: ack high for 10 cycles,
    // clk_en high for 14, so run_cnt ends at 14.
    task automatic test_run_drain();
        exp_t       e;
        logic [2:0] st;
        logic [15:0] c;
        do_reset();
        for (int j = 0; j <= 17; j++) begin
            if (j < 2)       st = S_WAKE;
            else if (j < 12) st = S_RUN;
            else if (j < 16) st = S_DRAIN;
            else             st = S_IDLE;
            if (j <= 2)       c = 16'd0;
            else if (j <= 16) c = 16'(j - 2);
            else              c = 16'd14;
            push_exp("run_drain", st, (j >= 2) && (j < 16),
                     ((j >= 2) && (j < 12)) ? 4'b0100 : 4'b0000, c, 1'b1);
            tick((j < 12) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.state !== e.st || bus.clk_en !== e.en || bus.ack !== e.ack ||
                bus.busy !== (e.st != S_IDLE) || (e.use_cnt && bus.run_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL %s[%0d]: got st=%0d en=%b ack=%b busy=%b cnt=%0d want st=%0d en=%b ack=%b cnt=%0d",
                         e.name, j, bus.state, bus.clk_en, bus.ack, bus.busy, bus.run_cnt,
                         e.st, e.en, e.ack, e.cnt);
            end
        end
    endtask

    // Re-request on the 2nd DRAIN cycle, then again on the expiry edge.
    task automatic test_rewake();
        exp_t       e;
        logic [2:0] st;
        logic [3:0] r;
        for (int j = 0; j <= 18; j++) begin
            if (j < 4 || j == 6 || j == 7 || j == 12 || j == 13) r = 4'b0001;
            else                                                 r = 4'b0000;
            if (j < 2)                              st = S_WAKE;
            else if (j < 4 || (j >= 6 && j < 8))    st = S_RUN;
            else if (j < 6 || (j >= 8 && j < 12))  st = S_DRAIN;
            else if (j < 14)                        st = S_RUN;
            else if (j < 18)                        st = S_DRAIN;
            else                                    st = S_IDLE;
            push_exp("rewake", st, (j >= 2) && (j < 18),
                     (st == S_RUN) ? 4'b0001 : 4'b0000,
                     (j <= 2) ? 16'd14 : 16'(12 + j), 1'b1);
            tick(r, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.state !== e.st || bus.clk_en !== e.en || bus.ack !== e.ack ||
                bus.busy !== (e.st != S_IDLE) || (e.use_cnt && bus.run_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL %s[%0d]: got st=%0d en=%b ack=%b busy=%b cnt=%0d want st=%0d en=%b ack=%b cnt=%0d",
                         e.name, j, bus.state, bus.clk_en, bus.ack, bus.busy, bus.run_cnt,
                         e.st, e.en, e.ack, e.cnt);
            end
        end
    endtask

    // All requests high; halt pulsed for 3 cycles while in RUN.
    task automatic test_halt();
        exp_t       e;
        logic [2:0] st;
        logic [15:0] c;
        for (int j = 0; j <= 9; j++) begin
            if (j < 2)      st = S_WAKE;
            else if (j < 4) st = S_RUN;
            else if (j < 7) st = S_IDLE;
            else if (j < 9) st = S_WAKE;
            else            st = S_RUN;
            if (j <= 2)      c = 16'd30;
            else if (j == 3) c = 16'd31;
            else             c = 16'd32;
            push_exp("halt", st, st == S_RUN, (st == S_RUN) ? 4'b1111 : 4'b0000, c, 1'b1);
            tick(4'b1111, (j >= 4) && (j <= 6), 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.state !== e.st || bus.clk_en !== e.en || bus.ack !== e.ack ||
                bus.busy !== (e.st != S_IDLE) || (e.use_cnt && bus.run_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL %s[%0d]: got st=%0d en=%b ack=%b busy=%b cnt=%0d want st=%0d en=%b ack=%b cnt=%0d",
                         e.name, j, bus.state, bus.clk_en, bus.ack, bus.busy, bus.run_cnt,
                         e.st, e.en, e.ack, e.cnt);
            end
        end
    endtask

    // Continues from RUN left by test_halt; rst asserted mid-run.
    task automatic test_reset_midrun();
        exp_t e;
        for (int j = 0; j <= 2; j++) begin
            if (j == 0) push_exp("reset_midrun", S_RUN, 1'b1, 4'b1111, 16'd33, 1'b1);
            else        push_exp("reset_midrun", S_INIT, 1'b0, 4'b0000, 16'd0, 1'b1);
            tick(4'b1111, 1'b0, j != 0);
            e = sb.pop_front();
            checks++;
            if (bus.state !== e.st || bus.clk_en !== e.en || bus.ack !== e.ack ||
                bus.busy !== (e.st != S_IDLE) || (e.use_cnt && bus.run_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL %s[%0d]: got st=%0d en=%b ack=%b busy=%b cnt=%0d want st=%0d en=%b ack=%b cnt=%0d",
                         e.name, j, bus.state, bus.clk_en, bus.ack, bus.busy, bus.run_cnt,
                         e.st, e.en, e.ack, e.cnt);
            end
        end
    endtask

    // CNT_W=4 instance held requesting for 30 cycles: stops at 15.
    task automatic test_saturation();
        exp_t e;
        do_reset();
        bus_s.req = 4'b0001;
        for (int j = 0; j < 30; j++) begin
            push_exp("saturation", (j < 2) ? S_WAKE : S_RUN, j >= 2, 4'b0001,
                     (j <= 2) ? 16'd0 : ((j - 2 > 15) ? 16'd15 : 16'(j - 2)), 1'b1);
            tick(4'b0000, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus_s.clk_en !== e.en || bus_s.run_cnt !== e.cnt[3:0]) begin
                failures++;
                $display("FAIL %s[%0d]: got en=%b cnt=%0d want en=%b cnt=%0d",
                         e.name, j, bus_s.clk_en, bus_s.run_cnt, e.en, e.cnt[3:0]);
            end
        end
        bus_s.req = 4'b0000;
    endtask

    initial begin
        bus.req    = 4'b0000;
        bus.halt   = 1'b0;
        bus_s.req  = 4'b0000;
        bus_s.halt = 1'b0;
        test_reset();
        test_holdoff();
        test_run_drain();
        test_rewake();
        test_halt();
        test_reset_midrun();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
